// File: rtl/timer_tima.sv
// DMG timer block for FF05 TIMA, FF06 TMA and FF07 TAC: counts falling edges of the
// TAC-selected divider tap, reloads TIMA from TMA one cycle after overflow and pulses int_timer.
module timer_tima #(
  parameter logic [2:0] TAC_RST = 3'b000,
  parameter logic [7:0] TMA_RST = 8'h00
) (
  input  logic       boga1mhz,
  input  logic       nreset2,
  input  logic       ff04_ff07,
  input  logic [1:0] a,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       _4096hz,
  input  logic       _262144hz,
  input  logic       _65536hz,
  input  logic       _16384hz,
  output logic       int_timer,
  output logic [7:0] tima_q
);

  localparam logic [1:0] ST_COUNT  = 2'b00;
  localparam logic [1:0] ST_OVF    = 2'b01;
  localparam logic [1:0] ST_RELOAD = 2'b10;

  logic [7:0] tima;
  logic [7:0] tma;
  logic [2:0] tac;
  logic       tap_prev;
  logic [1:0] state;
  logic       tap;
  logic       sel;
  logic       tick;
  logic       wr_tima;
  logic       wr_tma;
  logic       wr_tac;

  // Tap mux, falling-edge detect and write decode
  always_comb begin
    tap = 1'b0;
    case (tac[1:0])
      2'b00:   tap = _4096hz;
      2'b01:   tap = _262144hz;
      2'b10:   tap = _65536hz;
      2'b11:   tap = _16384hz;
      default: tap = 1'b0;
    endcase
    sel     = tac[2] & tap;
    tick    = tap_prev & ~sel;
    wr_tima = ff04_ff07 & cpu_wr & (a == 2'b01);
    wr_tma  = ff04_ff07 & cpu_wr & (a == 2'b10);
    wr_tac  = ff04_ff07 & cpu_wr & (a == 2'b11);
  end

  // Register state, counter, reload sequencing and CPU writes
  always_ff @(posedge boga1mhz) begin
    if (!nreset2) begin
      tima      <= 8'h00;
      tma       <= TMA_RST;
      tac       <= TAC_RST;
      tap_prev  <= 1'b0;
      state     <= ST_COUNT;
      int_timer <= 1'b0;
    end else begin
      tap_prev  <= sel;
      int_timer <= 1'b0;
      if (wr_tma) begin
        tma <= d_in;
      end
      if (wr_tac) begin
        tac <= d_in[2:0];
      end
      case (state)
        ST_OVF: begin
          // A TIMA write here cancels both the reload and the interrupt
          if (wr_tima) begin
            tima  <= d_in;
            state <= ST_COUNT;
          end else begin
            tima      <= tma;
            int_timer <= 1'b1;
            state     <= ST_RELOAD;
          end
        end
        ST_RELOAD: begin
          // TMA wins over a TIMA write; a TMA write is mirrored into TIMA
          state <= ST_COUNT;
          if (wr_tma) begin
            tima <= d_in;
          end
        end
        ST_COUNT: begin
          if (wr_tima) begin
            tima <= d_in;
          end else if (tick) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= ST_OVF;
            end else begin
              tima <= tima + 8'h01;
            end
          end
        end
        default: begin
          state <= ST_COUNT;
        end
      endcase
    end
  end

  // CPU read mux; FF04 belongs to the divider so it is not driven here
  always_comb begin
    d_oe  = ff04_ff07 & cpu_rd & (a != 2'b00);
    d_out = 8'h00;
    case (a)
      2'b01:   d_out = tima;
      2'b10:   d_out = tma;
      2'b11:   d_out = {5'b11111, tac};
      default: d_out = 8'h00;
    endcase
  end

  assign tima_q = tima;

endmodule

// File: tb/tb_timer_tima.sv
// Self-checking bench for timer_tima: directed scenarios followed by randomized traffic,
// all compared against a cycle-level behavioural model of the timer rules.
module tb_timer_tima;

  logic       clk;
  logic       nrst;
  logic       ff;
  logic [1:0] a;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] d_out;
  logic       d_oe;
  logic       t4096;
  logic       t262k;
  logic       t65k;
  logic       t16k;
  logic       int_timer;
  logic [7:0] tima_q;

  int n_checks;
  int n_fails;

  // reference model state
  int m_tima;
  int m_tma;
  int m_tac;
  bit m_prev;
  int m_age;   // cycles since the FF->00 wrap: 0 idle, 1 overflow cycle, 2 reload cycle
  bit m_int;

  timer_tima dut (
    .boga1mhz (clk),
    .nreset2  (nrst),
    .ff04_ff07(ff),
    .a        (a),
    .cpu_wr   (wr),
    .cpu_rd   (rd),
    .d_in     (din),
    .d_out    (d_out),
    .d_oe     (d_oe),
    ._4096hz  (t4096),
    ._262144hz(t262k),
    ._65536hz (t65k),
    ._16384hz (t16k),
    .int_timer(int_timer),
    .tima_q   (tima_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_read(input logic [1:0] addr);
    case (addr)
      2'b01:   return m_tima;
      2'b10:   return m_tma;
      2'b11:   return 248 + m_tac;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock using the current input values
  task automatic model_step();
    bit [3:0] taps;
    bit sel;
    bit tick;
    bit w_tima, w_tma, w_tac;
    taps   = {t16k, t65k, t262k, t4096};
    sel    = (m_tac >= 4) && taps[m_tac % 4];
    tick   = m_prev && !sel;
    w_tima = ff && wr && (a == 2'd1);
    w_tma  = ff && wr && (a == 2'd2);
    w_tac  = ff && wr && (a == 2'd3);
    if (!nrst) begin
      m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; m_age = 0; m_int = 0;
      return;
    end
    m_int = 0;
    if (m_age == 1) begin
      if (w_tima) begin
        m_tima = din; m_age = 0;
      end else begin
        m_tima = m_tma; m_age = 2; m_int = 1;
      end
    end else if (m_age == 2) begin
      m_age = 0;
      if (w_tma) m_tima = din;
    end else if (w_tima) begin
      m_tima = din;
    end else if (tick) begin
      m_tima = m_tima + 1;
      if (m_tima == 256) begin
        m_tima = 0; m_age = 1;
      end
    end
    if (w_tma) m_tma = din;
    if (w_tac) m_tac = din % 8;
    m_prev = sel;
  endtask

  // One clock: check combinational read path, step model and DUT, then check outputs
  task automatic cycle();
    logic exp_oe;
    #1;
    exp_oe = ff & rd & (a != 2'b00);
    check("d_oe", d_oe, exp_oe);
    if (exp_oe) check("d_out", d_out, model_read(a));
    model_step();
    @(posedge clk);
    #1;
    check("tima", tima_q, m_tima[7:0]);
    check("int_timer", int_timer, m_int);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
    ff = 1'b1; wr = 1'b1; a = addr; din = data;
    cycle();
    ff = 1'b0; wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    ff = 1'b1; rd = 1'b1; a = addr;
    #1;
    check({tag, "_oe"}, d_oe, 8'h01);
    check(tag, d_out, exp);
    ff = 1'b0; rd = 1'b0;
  endtask

  task automatic fall_262k();
    t262k = 1'b1; cycle();
    t262k = 1'b0; cycle();
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    nrst = 1'b0; ff = 1'b0; a = 2'b00; wr = 1'b0; rd = 1'b0; din = 8'h00;
    t4096 = 1'b0; t262k = 1'b0; t65k = 1'b0; t16k = 1'b0;
    @(negedge clk);

    // 1: reset values
    idle(2);
    nrst = 1'b1;
    #1;
    check("rst_tima", tima_q, 8'h00);
    check("rst_int", int_timer, 8'h00);
    check("rst_oe_idle", d_oe, 8'h00);
    read_check("rst_tac", 2'b11, 8'hF8);
    read_check("rst_tma", 2'b10, 8'h00);

    // 2: counting enabled, then disabled
    cpu_write(2'b11, 8'h05);
    for (int i = 0; i < 4; i++) fall_262k();
    check("count4", tima_q, 8'h04);
    cpu_write(2'b11, 8'h01);
    for (int i = 0; i < 4; i++) fall_262k();
    check("disabled", tima_q, 8'h04);

    // 3: overflow and reload
    cpu_write(2'b10, 8'hF0);
    cpu_write(2'b01, 8'hFF);
    cpu_write(2'b11, 8'h05);
    fall_262k();
    check("ovf_tima", tima_q, 8'h00);
    check("ovf_int", int_timer, 8'h00);
    cycle();
    check("reload_tima", tima_q, 8'hF0);
    check("reload_int", int_timer, 8'h01);
    cycle();
    check("after_int", int_timer, 8'h00);

    // 4a: TIMA write in the overflow cycle cancels reload
    cpu_write(2'b01, 8'hFF);
    fall_262k();
    cpu_write(2'b01, 8'h42);
    check("ovf_wr_tima", tima_q, 8'h42);
    check("ovf_wr_int", int_timer, 8'h00);
    idle(2);
    check("ovf_wr_hold", tima_q, 8'h42);

    // 4b: TIMA write in the reload cycle is ignored
    cpu_write(2'b01, 8'hFF);
    fall_262k();
    cycle();
    cpu_write(2'b01, 8'h42);
    check("rld_wr_tima", tima_q, 8'hF0);

    // 5: glitch increment when the enable is cleared while the tap is high
    cpu_write(2'b01, 8'h10);
    t262k = 1'b1;
    cycle();
    cpu_write(2'b11, 8'h01);
    cycle();
    check("glitch_inc", tima_q, 8'h11);
    t262k = 1'b0;
    cpu_write(2'b11, 8'h04);
    cycle();
    cpu_write(2'b11, 8'h01);
    cycle();
    check("no_glitch", tima_q, 8'h11);

    // 6: reset in the overflow cycle aborts the reload
    cpu_write(2'b11, 8'h05);
    cpu_write(2'b01, 8'hFF);
    fall_262k();
    check("pre_rst_ovf", tima_q, 8'h00);
    nrst = 1'b0;
    cycle();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_ovf_int", int_timer, 8'h00);
    end
    check("rst_ovf_tima", tima_q, 8'h00);
    read_check("rst_ovf_tma", 2'b10, 8'h00);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) t4096 = ~t4096;
      if ($urandom_range(1) == 0) t262k = ~t262k;
      if ($urandom_range(2) == 0) t65k = ~t65k;
      if ($urandom_range(3) == 0) t16k = ~t16k;
      ff   = ($urandom_range(1) == 0);
      a    = 2'($urandom_range(3));
      wr   = ($urandom_range(9) == 0);
      rd   = ($urandom_range(1) == 0);
      din  = ($urandom_range(1) == 0) ? 8'($urandom_range(255, 252)) : 8'($urandom_range(255));
      if (wr && a == 2'b11 && $urandom_range(3) != 0) din[2] = 1'b1;
      nrst = ($urandom_range(599) != 0);
      cycle();
    end
    nrst = 1'b1; ff = 1'b0; wr = 1'b0; rd = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
